sudoku_check_sequencer: RTL and testbench

- Controller that sequences rule checking of the stored sudoku board.
- Walks all 27 groups (9 rows, 9 columns, 9 boxes), 9 cells each, issuing one read per cycle to the board storage's read port.
- Checks each returned value against a per-group "seen" bitmask and reports the result: pass/fail, first failing group, error count and completeness.
- Sits between the board register array and the top-level status pins; replaces ad-hoc checking in the top module.

---
 rtl/sudoku_check_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sudoku_check_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_check_sequencer.sv
// ---------------------------------------------------------------------------
// sudoku_check_sequencer
//
// Walks every rule group of a 9x9 sudoku board (9 rows, then 9 columns, then
// 9 boxes), issuing one read per cycle to the board storage. Each returned
// cell value is checked against a per-group "seen" bitmask. The block reports
// pass/fail, the first failing group, a saturating violation count and
// whether the board had no empty cells.
//
// Optional feature macro: CHECK_EARLY_ABORT_EN
//   defined   : the first violation stops the scan and goes straight to DONE
//   undefined : the full 243-read scan always runs and every violation counts
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request a full check (accepted in IDLE or DONE)
//   abort         synchronous cancel back to IDLE, results are held
//   rd_en         read strobe to board storage
//   rd_row/rd_col read address, 0..8
//   rd_data       cell value, valid one cycle after rd_en
//   busy          scan in progress (SCAN or DRAIN)
//   done          level, check finished
//   err           at least one violation found
//   complete      no empty cell seen
//   err_kind      first failing group kind: 0 row, 1 column, 2 box
//   err_idx       first failing group index 0..8
//   err_cnt       saturating violation count
// ---------------------------------------------------------------------------
module sudoku_check_sequencer #(
  parameter int BOX       = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 rd_en,
  output logic [3:0]           rd_row,
  output logic [3:0]           rd_col,
  input  logic [3:0]           rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 complete,
  output logic [1:0]           err_kind,
  output logic [3:0]           err_idx,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int         N     = BOX * BOX;
  localparam logic [3:0] BOX_L = 4'(BOX);
  localparam logic [3:0] LAST  = 4'(N - 1);
  localparam logic [3:0] N_L   = 4'(N);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t         state, next_state;
  logic [1:0]     phase, phase_d;
  logic [3:0]     g, k, g_d, k_d;
  logic           chk_pend;
  logic [N-1:0]   mask, eff_mask, val_bit;
  logic           go, scan_end, chk_valid;
  logic           is_empty, is_illegal, is_dup, violation;

  assign go       = start && !abort && (state == IDLE || state == DONE);
  assign scan_end = (phase == 2'd2) && (g == LAST) && (k == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort wins over everything, including start
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = SCAN;
        SCAN: begin
          if (scan_end) next_state = DRAIN;
`ifdef CHECK_EARLY_ABORT_EN
          if (violation) next_state = DONE;
`endif
        end
        DRAIN:   next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    rd_en = (state == SCAN);
    busy  = (state == SCAN) || (state == DRAIN);
    done  = (state == DONE);
  end

  // Group/cell counters to storage address
  always_comb begin
    rd_row = g;
    rd_col = k;
    case (phase)
      2'd0: begin rd_row = g; rd_col = k; end
      2'd1: begin rd_row = k; rd_col = g; end
      default: begin
        rd_row = BOX_L * (g / BOX_L) + k / BOX_L;
        rd_col = BOX_L * (g % BOX_L) + k % BOX_L;
      end
    endcase
  end

  // Check of the datum returned for the previous cycle's read. The mask is
  // treated as empty on the first cell of a group so groups never leak.
  always_comb begin
    eff_mask   = (k_d == 4'd0) ? '0 : mask;
    is_empty   = (rd_data == 4'd0);
    is_illegal = (rd_data > N_L);
    val_bit    = '0;
    if (!is_empty && !is_illegal) val_bit = {{(N-1){1'b0}}, 1'b1} << (rd_data - 4'd1);
    is_dup     = |(eff_mask & val_bit);
    chk_valid  = chk_pend && (state == SCAN || state == DRAIN) && !abort;
    violation  = chk_valid && (is_illegal || is_dup);
  end

  // Scan counters plus the one-cycle delayed copy that follows each read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 2'd0;
      g        <= 4'd0;
      k        <= 4'd0;
      phase_d  <= 2'd0;
      g_d      <= 4'd0;
      k_d      <= 4'd0;
      chk_pend <= 1'b0;
    end else begin
      phase_d  <= phase;
      g_d      <= g;
      k_d      <= k;
      chk_pend <= rd_en;
      if (go) begin
        phase <= 2'd0;
        g     <= 4'd0;
        k     <= 4'd0;
      end else if (state == SCAN && !abort) begin
        if (k == LAST) begin
          k <= 4'd0;
          if (g == LAST) begin
            g     <= 4'd0;
            phase <= phase + 2'd1;
          end else begin
            g <= g + 4'd1;
          end
        end else begin
          k <= k + 4'd1;
        end
      end
    end
  end

  // Result registers; cleared by an accepted start, held through abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      err      <= 1'b0;
      complete <= 1'b0;
      err_kind <= 2'd0;
      err_idx  <= 4'd0;
      err_cnt  <= '0;
    end else if (go) begin
      mask     <= '0;
      err      <= 1'b0;
      complete <= 1'b1;
      err_kind <= 2'd0;
      err_idx  <= 4'd0;
      err_cnt  <= '0;
    end else if (chk_valid) begin
      mask <= eff_mask | val_bit;
      if (is_empty) complete <= 1'b0;
      if (violation) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err) begin
          err_kind <= phase_d;
          err_idx  <= g_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sudoku_check_sequencer
//
// Directed bench for sudoku_check_sequencer. A behavioural board memory
// answers reads one cycle after rd_en. Each scan is started by a one-cycle
// start pulse (cycle S); the per-cycle trace of cycles S+1.. is recorded and
// then compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sudoku_check_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       rd_en;
  logic [3:0] rd_row, rd_col;
  logic [3:0] rd_data = 4'd0;
  logic       busy, done, err, complete;
  logic [1:0] err_kind;
  logic [3:0] err_idx;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] board [0:8][0:8];

  logic       busy_h [0:399];
  logic       rden_h [0:399];
  logic       done_h [0:399];
  logic       err_h  [0:399];
  logic [7:0] cnt_h  [0:399];
  logic [3:0] row_h  [0:399];
  logic [3:0] col_h  [0:399];
  logic [26:0] rst_snap;

  int first_done, busy_cnt, last_busy, rden_cnt, addr_bad;

  sudoku_check_sequencer #(.BOX(3), .ERR_CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .complete (complete),
    .err_kind (err_kind),
    .err_idx  (err_idx),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Board storage: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en && rd_row < 4'd9 && rd_col < 4'd9) rd_data <= board[rd_row][rd_col];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fillValid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  // Pulse start (cycle S), then trace cycles S+1..S+ncyc while injecting
  // abort / extra start / reset at the requested offsets (0 = never).
  task automatic applyStimulus(input int ncyc, input int abort_at, input int restart_at,
                               input int rst_at, input int extra_start_at);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      if (t > 1) @(negedge clk);
      busy_h[t] = busy;
      rden_h[t] = rd_en;
      done_h[t] = done;
      err_h[t]  = err;
      cnt_h[t]  = err_cnt;
      row_h[t]  = rd_row;
      col_h[t]  = rd_col;
      abort = (t == abort_at);
      start = (t == restart_at) || (t == extra_start_at);
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        rst_snap = {busy, done, rd_en, err, complete, err_kind, err_idx, err_cnt, rd_row, rd_col};
      end
      if (rst_at != 0 && t == rst_at + 2) rst_n = 1'b1;
    end
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  // Reduce the trace of a plain scan to timing figures and address errors
  task automatic summarize(input int ncyc);
    int i, p, gg, kk, er, ec;
    first_done = 0; busy_cnt = 0; last_busy = 0; rden_cnt = 0; addr_bad = 0;
    for (int t = 1; t <= ncyc; t++) begin
      if (done_h[t] && first_done == 0) first_done = t;
      if (busy_h[t]) begin busy_cnt++; last_busy = t; end
      if (rden_h[t]) begin
        rden_cnt++;
        i  = t - 1;
        p  = i / 81;
        gg = (i / 9) % 9;
        kk = i % 9;
        if (p == 0)      begin er = gg; ec = kk; end
        else if (p == 1) begin er = kk; ec = gg; end
        else begin
          er = 3 * (gg / 3) + kk / 3;
          ec = 3 * (gg % 3) + kk % 3;
        end
        if (t > 243 || int'(row_h[t]) != er || int'(col_h[t]) != ec) addr_bad++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fillValid();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    checkOutput("rst_rd_en",    32'(rd_en),    32'd0);
    checkOutput("rst_err",      32'(err),      32'd0);
    checkOutput("rst_complete", 32'(complete), 32'd0);
    checkOutput("rst_err_cnt",  32'(err_cnt),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] valid solved board");
    applyStimulus(260, 0, 0, 0, 0);
    summarize(260);
    checkOutput("valid_first_done", 32'(first_done), 32'd245);
    checkOutput("valid_busy_cnt",   32'(busy_cnt),   32'd244);
    checkOutput("valid_last_busy",  32'(last_busy),  32'd244);
    checkOutput("valid_rden_cnt",   32'(rden_cnt),   32'd243);
    checkOutput("valid_addr_bad",   32'(addr_bad),   32'd0);
    checkOutput("valid_err",        32'(err),        32'd0);
    checkOutput("valid_complete",   32'(complete),   32'd1);
    checkOutput("valid_err_cnt",    32'(err_cnt),    32'd0);

    $display("[TB] empty cell at (0,0)");
    board[0][0] = 4'd0;
    applyStimulus(260, 0, 0, 0, 0);
    summarize(260);
    checkOutput("empty_first_done", 32'(first_done), 32'd245);
    checkOutput("empty_err",        32'(err),        32'd0);
    checkOutput("empty_complete",   32'(complete),   32'd0);

    $display("[TB] cells (4,1) and (4,2) swapped");
    fillValid();
    board[4][1] = 4'd7;
    board[4][2] = 4'd6;
    applyStimulus(260, 0, 0, 0, 0);
    summarize(260);
    checkOutput("swap_err",      32'(err),      32'd1);
    checkOutput("swap_err_kind", 32'(err_kind), 32'd1);
    checkOutput("swap_err_idx",  32'(err_idx),  32'd1);
`ifdef CHECK_EARLY_ABORT_EN
    checkOutput("swap_err_cnt",    32'(err_cnt), 32'd1);
    checkOutput("swap_early_done", 32'(first_done > 0 && first_done < 245), 32'd1);
`else
    checkOutput("swap_err_cnt",    32'(err_cnt),    32'd2);
    checkOutput("swap_first_done", 32'(first_done), 32'd245);
`endif

    $display("[TB] illegal value 12 at (8,8)");
    fillValid();
    board[8][8] = 4'd12;
    applyStimulus(260, 0, 0, 0, 0);
    summarize(260);
    checkOutput("ill_err",      32'(err),      32'd1);
    checkOutput("ill_err_kind", 32'(err_kind), 32'd0);
    checkOutput("ill_err_idx",  32'(err_idx),  32'd8);
`ifdef CHECK_EARLY_ABORT_EN
    checkOutput("ill_err_cnt",  32'(err_cnt),  32'd1);
`else
    checkOutput("ill_err_cnt",  32'(err_cnt),  32'd3);
`endif

    $display("[TB] abort at S+50, restart at S+60");
    fillValid();
    board[0][1] = 4'd12;
    applyStimulus(320, 50, 60, 0, 0);
    checkOutput("abort_busy",      32'(busy_h[51]), 32'd0);
    checkOutput("abort_rd_en",     32'(rden_h[51]), 32'd0);
    checkOutput("abort_done",      32'(done_h[51]), 32'd0);
    checkOutput("abort_err_held",  32'(err_h[51]),  32'd1);
    checkOutput("abort_idle_rden", 32'(rden_h[60]), 32'd0);
    checkOutput("restart_rd_en",   32'(rden_h[61]), 32'd1);
    checkOutput("restart_row",     32'(row_h[61]),  32'd0);
    checkOutput("restart_col",     32'(col_h[61]),  32'd0);
    checkOutput("restart_cnt_clr", 32'(cnt_h[61]),  32'd0);
`ifdef CHECK_EARLY_ABORT_EN
    checkOutput("restart_err_cnt", 32'(err_cnt), 32'd1);
`else
    checkOutput("abort_cnt_before", 32'(cnt_h[50]), 32'd1);
    checkOutput("restart_done_304", 32'(done_h[304]), 32'd0);
    checkOutput("restart_done_305", 32'(done_h[305]), 32'd1);
    checkOutput("restart_err_cnt",  32'(err_cnt),     32'd3);
`endif

    $display("[TB] async reset at S+100");
    fillValid();
    applyStimulus(260, 0, 0, 100, 0);
    checkOutput("areset_outputs",   32'(rst_snap),    32'd0);
    checkOutput("areset_busy_held", 32'(busy_h[101]), 32'd0);
    checkOutput("areset_idle_busy", 32'(busy_h[103]), 32'd0);
    checkOutput("areset_no_done",   32'(done_h[250]), 32'd0);

    $display("[TB] start while busy");
    applyStimulus(260, 0, 0, 0, 30);
    summarize(260);
    checkOutput("busystart_first_done", 32'(first_done), 32'd245);
    checkOutput("busystart_busy_cnt",   32'(busy_cnt),   32'd244);
    checkOutput("busystart_rden_cnt",   32'(rden_cnt),   32'd243);
    checkOutput("busystart_addr_bad",   32'(addr_bad),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
